i_memory: RTL and testbench
===========================

# i_memory

Memory-stage block of the single-cycle 64-bit LEGv8 datapath. It holds the data memory, services loads and stores from the execute stage, and resolves the branch decision that selects the next PC. Loads and branch resolution are combinational; stores commit on the rising clock edge. A companion free-running clock generator, `oscillator`, drives `clk` in simulation.

## Interface
- Parameters
- WORD, 64: datapath width in bits; data and address width.
- DEPTH, 64: number of doubleword entries in data memory (512 bytes).
- CYCLE, 10: clock period in time units; used by `oscillator` only.
- Ports
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- zero  in  1  ALU zero flag from execute.
- uncondbranch  in  1  unconditional branch (B).
- branch  in  1  conditional branch on zero (CBZ).
- mem_read  in  1  load enable.
- mem_write  in  1  store enable.
- mem_address  in  WORD  byte address, from the ALU result.
- mem_write_data  in  WORD  store data.
- pc_src  out  1  1 selects the branch target as the next PC.
- mem_read_data  out  WORD  load data.
- `oscillator` has one port: clk  out  1.

## Operation
- Branch resolution, combinational: pc_src = uncondbranch | (branch & zero).
  - It is independent of clk, rst and the memory controls.
- Memory array: DEPTH entries of WORD bits.
  - Index = mem_address[3+log2(DEPTH)-1 : 3], which is bits [8:3] at default parameters.
  - Bits [2:0] are ignored, so all accesses are doubleword-aligned.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*8 bytes.
- Store: at a rising edge with mem_write=1 and rst=0, the indexed entry takes mem_write_data.
- Load, combinational:
  - mem_read=1: mem_read_data = the indexed entry.
  - mem_read=0: mem_read_data = 0.
- mem_read and mem_write both 1 at the same address:
  - Before the edge, the output shows the old contents.
  - After the edge, it shows the new value. There is no bypass.
- Reset: a rising edge with rst=1 clears every entry to 0. Reset takes priority over a concurrent store.
- Unknown or undriven controls need no defined outputs, but they must never corrupt the array unless mem_write=1.
- oscillator: simulation only.
  - clk starts at 0 and toggles every CYCLE/2.
  - Duty is 50% and it runs until $finish.

## Timing
- Store latency: 1 edge. Data written at edge N is readable combinationally immediately after edge N.
- Load latency: 0 cycles; output follows mem_address and mem_read within the same cycle.
- pc_src latency: 0 cycles.
- Output values after reset:
  - mem_read_data = 0 for every address.
  - pc_src depends only on its inputs.
- Reset asserted mid-sequence: all entries read 0 from the next edge, and stores in that cycle are discarded.
- Benches change stimulus on the falling edge and sample half a cycle later.

## Test plan
- Reset, then mem_read=1 at addresses 0, 16, 32 and 64 -> mem_read_data=0 each time. With mem_read=0 at address 64 -> 0.
- Store -168 at address 16, then 12345 at address 64, one edge each. Load 16 -> -168 (0xFFFFFFFFFFFFFF58); load 64 -> 12345; load 32 -> 0.
- Store with mem_read=0 -> mem_read_data stays 0.
- Address aliasing:
  - Store 0xA5 at address 19; load 16 -> 0xA5.
  - Store 7 at address 512+8; load 8 -> 7.
- Reset priority:
  - rst=1 and mem_write=1 in the same cycle, data 99 at address 24 -> load 24 returns 0.
  - A later reset clears the earlier value at address 16 to 0.
- pc_src truth table for (uncondbranch, branch, zero):
  - (1,0,0) -> 1
  - (0,0,0) -> 0
  - (0,1,0) -> 0
  - (0,1,1) -> 1
  - (0,0,1) -> 0
  - (1,1,1) -> 1

Source files
------------

// File: rtl/i_memory.sv
// Memory stage of the single-cycle LEGv8 datapath: doubleword data memory with
// combinational loads, clocked stores and combinational branch resolution.
module i_memory #(
  parameter int unsigned WORD  = 64,
  parameter int unsigned DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            zero,
  input  logic            uncondbranch,
  input  logic            branch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [WORD-1:0] mem_address,
  input  logic [WORD-1:0] mem_write_data,
  output logic            pc_src,
  output logic [WORD-1:0] mem_read_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned IDX_LO = 3;
  localparam int unsigned IDX_HI = IDX_LO + IDX_W - 1;

  logic [WORD-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             unused_addr_bits;

  // Byte offset and bits above the array span are dropped, so accesses are
  // doubleword-aligned and wrap modulo the memory size.
  assign idx              = mem_address[IDX_HI:IDX_LO];
  assign unused_addr_bits = ^{mem_address[WORD-1:IDX_HI+1], mem_address[IDX_LO-1:0]};

  assign pc_src = uncondbranch | (branch & zero);

  // Reset clears the whole array and wins over a concurrent store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[idx] <= mem_write_data;
    end
  end

  always_comb begin
    mem_read_data = '0;
    if (mem_read) begin
      mem_read_data = mem[idx];
    end
  end

endmodule

// File: tb/tb_i_memory.sv
// Self-checking bench for i_memory: directed vector table plus randomized
// traffic compared against an array-based reference model.
module tb_i_memory;

  localparam int unsigned WORD  = 64;
  localparam int unsigned DEPTH = 64;

  logic            clk;
  logic            rst;
  logic            zero;
  logic            uncondbranch;
  logic            branch;
  logic            mem_read;
  logic            mem_write;
  logic [WORD-1:0] mem_address;
  logic [WORD-1:0] mem_write_data;
  logic            pc_src;
  logic [WORD-1:0] mem_read_data;

  int compared;
  int mismatched;

  i_memory #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .zero          (zero),
    .uncondbranch  (uncondbranch),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .pc_src        (pc_src),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            we;
    logic            re;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
    logic            ub;
    logic            br;
    logic            z;
    logic [WORD-1:0] exp_data;
    logic            exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic we, input logic re,
                              input logic [WORD-1:0] a, input logic [WORD-1:0] d,
                              input logic ub, input logic br, input logic z,
                              input logic [WORD-1:0] ed, input logic ep);
    vec_t v;
    v.rst = r; v.we = we; v.re = re; v.addr = a; v.wdata = d;
    v.ub = ub; v.br = br; v.z = z; v.exp_data = ed; v.exp_pc = ep;
    return v;
  endfunction

  task automatic check_data(input string name, input logic [WORD-1:0] exp);
    compared++;
    if (mem_read_data !== exp) begin
      mismatched++;
      $display("FAIL %s: mem_read_data got %h expected %h", name, mem_read_data, exp);
    end
  endtask

  task automatic check_pc(input string name, input logic exp);
    compared++;
    if (pc_src !== exp) begin
      mismatched++;
      $display("FAIL %s: pc_src got %b expected %b", name, pc_src, exp);
    end
  endtask

  // Drive on the falling edge, sample just before the following rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; mem_write = v.we; mem_read = v.re;
    mem_address = v.addr; mem_write_data = v.wdata;
    uncondbranch = v.ub; branch = v.br; zero = v.z;
    #4;
  endtask

  logic [WORD-1:0] model [DEPTH];
  logic [WORD-1:0] neg168;

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0; zero = 1'b0; uncondbranch = 1'b0; branch = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_write_data = '0;
    neg168 = -64'sd168;

    //             rst  we   re   addr      wdata     ub   br   z    exp_data  exp_pc
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 64'd0,   64'd0,     1'b1, 1'b0, 1'b0, 64'd0,     1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd0,   64'd0,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd16,  64'd0,     1'b0, 1'b1, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd32,  64'd0,     1'b0, 1'b1, 1'b1, 64'd0,     1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd64,  64'd0,     1'b0, 1'b0, 1'b1, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 64'd64,  64'd0,     1'b1, 1'b1, 1'b1, 64'd0,     1'b1));
    // Stores; the read-while-write at 64 must still show the old contents.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 64'd16,  neg168,    1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 64'd64,  64'd12345, 1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd16,  64'd0,     1'b0, 1'b0, 1'b0, neg168,    1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd64,  64'd0,     1'b0, 1'b0, 1'b0, 64'd12345, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd32,  64'd0,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 64'd16,  64'd0,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    // Aliasing: byte offset and bits above the array are ignored.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 64'd19,  64'hA5,    1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd16,  64'd0,     1'b0, 1'b0, 1'b0, 64'hA5,    1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 64'd520, 64'd7,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd8,   64'd0,     1'b0, 1'b0, 1'b0, 64'd7,     1'b0));
    // Reset beats a concurrent store and clears older data.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 64'd24,  64'd99,    1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd24,  64'd0,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd16,  64'd0,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 64'd8,   64'd0,     1'b0, 1'b0, 1'b0, 64'd0,     1'b0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check_data($sformatf("vec%0d_data", i), vecs[i].exp_data);
      check_pc($sformatf("vec%0d_pc", i), vecs[i].exp_pc);
    end

    // Randomized traffic: model is cleared by the last reset vector above.
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      int unsigned slot;
      v.rst = ($urandom_range(0, 39) == 0);
      v.we  = $urandom_range(0, 1);
      v.re  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        v.addr = {$urandom, $urandom};
      else
        v.addr = 64'($urandom_range(0, 1023));
      v.wdata = {$urandom, $urandom};
      v.ub = $urandom_range(0, 1);
      v.br = $urandom_range(0, 1);
      v.z  = $urandom_range(0, 1);
      slot = 32'((v.addr / 64'd8) % 64'(DEPTH));
      v.exp_data = v.re ? model[slot] : '0;
      v.exp_pc = (v.ub == 1'b1) || (v.br == 1'b1 && v.z == 1'b1);
      apply(v);
      check_data($sformatf("rnd%0d_data", n), v.exp_data);
      check_pc($sformatf("rnd%0d_pc", n), v.exp_pc);
      if (v.rst) begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end else if (v.we) begin
        model[slot] = v.wdata;
      end
    end

    // Sweep every entry after a final edge to catch stale or misplaced data.
    @(negedge clk);
    mem_write = 1'b0; rst = 1'b0; mem_read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem_address = 64'(i * 8);
      #1;
      check_data($sformatf("sweep%0d", i), model[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
